idma_axis_loopback_accel: RTL and testbench

- Synthesizable AXI-Stream responder that sits at the far end of the iDMA AXI-Stream backend. It is the accelerator endpoint the DMA streams into and reads back from.
- It sinks beats from the DMA write stream, applies a per-beat data transform, buffers the results in a FIFO and sources them back onto the DMA read stream.
- It replaces behavioural fake accelerators in wrapper benches and serves as a reference endpoint for FPGA bring-up.

---
 rtl/idma_axis_accel_pkg.sv | 57 +++++
 rtl/idma_axis_accel_fifo.sv | 50 +++++
 rtl/idma_axis_loopback_accel.sv | 107 ++++++++++
 tb/tb_idma_axis_loopback_accel.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/idma_axis_accel_pkg.sv
// Shared types and per-beat transform for the iDMA AXI-Stream loopback accelerator.
package idma_axis_accel_pkg;

  localparam int unsigned AxisDataWidth = 64;
  localparam int unsigned AxisStrbWidth = AxisDataWidth / 8;
  localparam int unsigned AxisIdWidth   = 4;
  localparam int unsigned AxisUserWidth = 4;

  typedef enum logic [1:0] {
    OP_PASS  = 2'd0,
    OP_ADD   = 2'd1,
    OP_BSWAP = 2'd2,
    OP_INV   = 2'd3
  } op_e;

  typedef struct packed {
    logic [AxisDataWidth-1:0] tdata;
    logic [AxisStrbWidth-1:0] tstrb;
    logic [AxisStrbWidth-1:0] tkeep;
    logic                     tlast;
    logic [AxisIdWidth-1:0]   tid;
    logic [AxisIdWidth-1:0]   tdest;
    logic [AxisUserWidth-1:0] tuser;
  } axis_t_chan_t;

  typedef struct packed {
    logic         tvalid;
    axis_t_chan_t t;
  } axis_req_t;

  typedef struct packed {
    logic tready;
  } axis_rsp_t;

  // tid/tdest are swapped so the reply routes back to the requester.
  function automatic axis_t_chan_t transform_beat(op_e op, axis_t_chan_t t_chan,
                                                  logic [AxisDataWidth-1:0] add_const);
    axis_t_chan_t r;
    r       = t_chan;
    r.tid   = t_chan.tdest;
    r.tdest = t_chan.tid;
    case (op)
      OP_ADD:   r.tdata = t_chan.tdata + add_const;
      OP_BSWAP: begin
        for (int i = 0; i < AxisStrbWidth; i++) begin
          r.tdata[8*i +: 8] = t_chan.tdata[8*(AxisStrbWidth-1-i) +: 8];
          r.tkeep[i]        = t_chan.tkeep[AxisStrbWidth-1-i];
          r.tstrb[i]        = t_chan.tstrb[AxisStrbWidth-1-i];
        end
      end
      OP_INV:   r.tdata = ~t_chan.tdata;
      default:  ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/idma_axis_accel_fifo.sv
// Synchronous FIFO; the head entry is read straight out of the storage array.
module idma_axis_accel_fifo #(
  parameter int unsigned Depth  = 16,
  parameter type         elem_t = logic,
  localparam int unsigned AddrW = $clog2(Depth),
  localparam int unsigned LvlW  = AddrW + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            i_push,
  input  logic            i_pop,
  input  elem_t           i_data,
  output elem_t           o_data,
  output logic            o_full,
  output logic            o_empty,
  output logic [LvlW-1:0] o_level
);

  elem_t            r_mem [Depth];
  logic [AddrW-1:0] r_wr_ptr;
  logic [AddrW-1:0] r_rd_ptr;
  logic [LvlW-1:0]  r_level;

  always_ff @(posedge clk_i) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers wrap naturally; full/empty come only from the level counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: ;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = (r_level == LvlW'(Depth));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;

endmodule

// File: rtl/idma_axis_loopback_accel.sv
// AXI-Stream loopback endpoint: sink -> transform -> FIFO -> source, with beat/packet counters.
module idma_axis_loopback_accel #(
  parameter int unsigned            DataWidth = idma_axis_accel_pkg::AxisDataWidth,
  parameter int unsigned            StrbWidth = DataWidth / 8,
  parameter int unsigned            Depth     = 16,
  parameter logic [DataWidth-1:0]   AddConst  = '0,
  parameter type axis_req_t    = idma_axis_accel_pkg::axis_req_t,
  parameter type axis_rsp_t    = idma_axis_accel_pkg::axis_rsp_t,
  parameter type axis_t_chan_t = idma_axis_accel_pkg::axis_t_chan_t,
  localparam int unsigned LvlW = $clog2(Depth) + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [1:0]      op_i,
  input  logic            hold_i,
  input  axis_req_t       sink_req_i,
  output axis_rsp_t       sink_rsp_o,
  output axis_req_t       src_req_o,
  input  axis_rsp_t       src_rsp_i,
  output logic [31:0]     beat_cnt_o,
  output logic [31:0]     pkt_cnt_o,
  output logic [LvlW-1:0] level_o
);
  import idma_axis_accel_pkg::*;

  if (DataWidth != AxisDataWidth || StrbWidth != AxisStrbWidth) begin : g_width_check
    $error("DataWidth/StrbWidth must match the package stream widths");
  end

  typedef enum logic {S_IDLE, S_PRESENT} src_state_e;

  src_state_e      r_state, w_state_nxt;
  logic            r_init;
  logic [31:0]     r_beat_cnt, r_pkt_cnt;
  logic            w_full, w_empty, w_push, w_pop, w_src_valid, w_sink_ready;
  axis_t_chan_t    w_beat_in, w_head;
  logic [LvlW-1:0] w_level;

  // r_init keeps tready low for the cycle right after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_init <= 1'b0;
    else       r_init <= 1'b1;
  end

  assign w_sink_ready = r_init & ~w_full;
  assign w_push       = sink_req_i.tvalid & w_sink_ready;
  assign w_beat_in    = transform_beat(op_e'(op_i), sink_req_i.t, AddConst);

  idma_axis_accel_fifo #(
    .Depth  (Depth),
    .elem_t (axis_t_chan_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_beat_in),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // PRESENT marks a beat already on the bus and not yet taken: it stays valid
  // regardless of hold_i. After a handshake the next beat is offered straight
  // from IDLE, so hold_i can still block it.
  always_comb begin
    w_state_nxt = r_state;
    w_src_valid = 1'b0;
    case (r_state)
      S_IDLE:    w_src_valid = ~w_empty & ~hold_i;
      S_PRESENT: w_src_valid = 1'b1;
      default:   w_src_valid = 1'b0;
    endcase
    w_pop = w_src_valid & src_rsp_i.tready;
    if (w_src_valid && !src_rsp_i.tready) w_state_nxt = S_PRESENT;
    else                                  w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_beat_cnt <= '0;
      r_pkt_cnt  <= '0;
    end else begin
      if (w_push)                r_beat_cnt <= r_beat_cnt + 32'd1;
      if (w_pop && w_head.tlast) r_pkt_cnt  <= r_pkt_cnt + 32'd1;
    end
  end

  always_comb begin
    sink_rsp_o        = '0;
    sink_rsp_o.tready = w_sink_ready;
    src_req_o         = '0;
    src_req_o.tvalid  = w_src_valid;
    src_req_o.t       = w_head;
  end

  assign beat_cnt_o = r_beat_cnt;
  assign pkt_cnt_o  = r_pkt_cnt;
  assign level_o    = w_level;

endmodule

// File: tb/tb_idma_axis_loopback_accel.sv
// Bench for idma_axis_loopback_accel: vector table, directed corner sequences and a randomized run against a queue model.
module tb_idma_axis_loopback_accel;
  import idma_axis_accel_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam logic [63:0] ADD_C = 64'h1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hold = 1'b0;
  logic [1:0]  op = 2'd0;
  axis_req_t   sink_req, src_req;
  axis_rsp_t   sink_rsp, src_rsp;
  logic [31:0] beat_cnt, pkt_cnt;
  logic [4:0]  level;

  idma_axis_loopback_accel #(
    .DataWidth (64),
    .StrbWidth (8),
    .Depth     (DEPTH),
    .AddConst  (ADD_C)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .op_i       (op),
    .hold_i     (hold),
    .sink_req_i (sink_req),
    .sink_rsp_o (sink_rsp),
    .src_req_o  (src_req),
    .src_rsp_i  (src_rsp),
    .beat_cnt_o (beat_cnt),
    .pkt_cnt_o  (pkt_cnt),
    .level_o    (level)
  );

  always #5 clk = ~clk;

  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           first_acc = -1;
  int           first_out = -1;
  axis_t_chan_t exp_q[$];
  axis_t_chan_t got_q[$];
  axis_t_chan_t prev_t;
  logic         stalled = 1'b0;
  logic         acc = 1'b0;
  logic         hold_mode = 1'b0;
  logic         rand_ready = 1'b0;

  typedef struct {
    logic [1:0]  op;
    logic [63:0] din;
    logic [7:0]  kin;
    logic [63:0] dexp;
    logic [7:0]  kexp;
  } vec_t;
  vec_t vt[6];

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_note(string name);
    total++;
    bad++;
    $display("FAIL %s: condition not met (cycle %0d)", name, cyc);
  endtask

  // Reference transform written from the stream rules, not from the RTL.
  function automatic axis_t_chan_t model(logic [1:0] o, axis_t_chan_t t);
    axis_t_chan_t r;
    r       = t;
    r.tid   = t.tdest;
    r.tdest = t.tid;
    if (o == 2'd1) r.tdata = t.tdata + ADD_C;
    else if (o == 2'd2) begin
      r.tdata = {<<8{t.tdata}};
      r.tkeep = {<<{t.tkeep}};
      r.tstrb = {<<{t.tstrb}};
    end else if (o == 2'd3) r.tdata = ~t.tdata;
    return r;
  endfunction

  // One clock: called at the falling edge with inputs already set.
  task automatic step();
    if (hold_mode)  hold = ((cyc / 3) % 2) == 1;
    if (rand_ready) src_rsp.tready = 1'($urandom_range(0, 1));
    #1;
    acc = 1'b0;
    if (rst) begin
      exp_q.delete();
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("src_valid_held", 128'(src_req.tvalid), 128'(1));
        chk("src_t_stable", 128'(src_req.t), 128'(prev_t));
      end else if (hold) begin
        chk("hold_blocks_new", 128'(src_req.tvalid), 128'(0));
      end
      if (src_req.tvalid && src_rsp.tready) begin
        if (exp_q.size() == 0) fail_note("unexpected_beat");
        else chk("src_beat", 128'(src_req.t), 128'(exp_q.pop_front()));
        got_q.push_back(src_req.t);
        if (first_out < 0) first_out = cyc;
      end
      if (sink_req.tvalid && sink_rsp.tready) begin
        exp_q.push_back(model(op, sink_req.t));
        acc = 1'b1;
        if (first_acc < 0) first_acc = cyc;
      end
      stalled = src_req.tvalid & ~src_rsp.tready;
      prev_t  = src_req.t;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic set_beat(logic [63:0] d, logic [7:0] k, logic last, logic [3:0] id, logic [3:0] de);
    sink_req.tvalid  = 1'b1;
    sink_req.t.tdata = d;
    sink_req.t.tkeep = k;
    sink_req.t.tstrb = k;
    sink_req.t.tlast = last;
    sink_req.t.tid   = id;
    sink_req.t.tdest = de;
    sink_req.t.tuser = d[3:0];
  endtask

  task automatic send(logic [63:0] d, logic [7:0] k, logic last, logic [3:0] id, logic [3:0] de);
    set_beat(d, k, last, id, de);
    for (int n = 0; n < 300; n++) begin
      step();
      if (acc) return;
    end
    fail_note("send_timeout");
  endtask

  task automatic drain();
    sink_req.tvalid = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (exp_q.size() == 0 && level == 0) return;
      step();
    end
    fail_note("drain_timeout");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sink_req.tvalid = 1'b0;
    step();
    rst = 1'b0;
    got_q.delete();
    first_acc = -1;
    first_out = -1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vt[0] = '{2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'h0, 8'hFF};
    vt[1] = '{2'd1, 64'h7, 8'hFF, 64'h8, 8'hFF};
    vt[2] = '{2'd2, 64'h0102_0304_0506_0708, 8'h0F, 64'h0807_0605_0403_0201, 8'hF0};
    vt[3] = '{2'd3, 64'h0, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF};
    vt[4] = '{2'd0, 64'hDEAD_BEEF_CAFE_F00D, 8'h3C, 64'hDEAD_BEEF_CAFE_F00D, 8'h3C};
    vt[5] = '{2'd2, 64'h1122_3344_5566_7788, 8'h81, 64'h8877_6655_4433_2211, 8'h81};

    sink_req = '0;
    src_rsp.tready = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_level", 128'(level), 128'(0));
    chk("rst_beat_cnt", 128'(beat_cnt), 128'(0));
    chk("rst_pkt_cnt", 128'(pkt_cnt), 128'(0));
    chk("rst_src_valid", 128'(src_req.tvalid), 128'(0));
    chk("rst_sink_ready", 128'(sink_rsp.tready), 128'(0));
    step();
    chk("init_sink_ready", 128'(sink_rsp.tready), 128'(1));

    // PASS packet of 16 beats with routing swap
    op = 2'd0;
    for (int i = 1; i <= 16; i++) send(64'(i), 8'hFF, i == 16, 4'd3, 4'd5);
    drain();
    chk("pass_count", 128'(got_q.size()), 128'(16));
    for (int i = 0; i < 16; i++)
      chk("pass_beat", {got_q[i].tdata, got_q[i].tid, got_q[i].tdest, 3'b0, got_q[i].tlast},
          {64'(i + 1), 4'd5, 4'd3, 3'b0, i == 15});
    chk("pass_latency", 128'(first_out - first_acc), 128'(1));
    chk("pass_beat_cnt", 128'(beat_cnt), 128'(16));
    chk("pass_pkt_cnt", 128'(pkt_cnt), 128'(1));

    // Single-beat transform vectors
    for (int i = 0; i < 6; i++) begin
      got_q.delete();
      op = vt[i].op;
      send(vt[i].din, vt[i].kin, 1'b1, 4'd1, 4'd2);
      drain();
      chk("vec_data", 128'(got_q[0].tdata), 128'(vt[i].dexp));
      chk("vec_keep", 128'(got_q[0].tkeep), 128'(vt[i].kexp));
    end

    // Fill to Depth with the source stalled, then a 17th beat waits
    do_reset();
    op = 2'd0;
    src_rsp.tready = 1'b0;
    for (int i = 0; i < 16; i++) send(64'(100 + i), 8'hFF, 1'b0, 4'd0, 4'd0);
    chk("full_level", 128'(level), 128'(16));
    chk("full_sink_ready", 128'(sink_rsp.tready), 128'(0));
    set_beat(64'd116, 8'hFF, 1'b1, 4'd0, 4'd0);
    for (int n = 0; n < 3; n++) begin
      step();
      chk("full_no_accept", 128'(acc), 128'(0));
    end
    src_rsp.tready = 1'b1;
    send(64'd116, 8'hFF, 1'b1, 4'd0, 4'd0);
    drain();
    chk("full_count", 128'(got_q.size()), 128'(17));
    for (int i = 0; i < 17; i++) chk("full_order", 128'(got_q[i].tdata), 128'(100 + i));

    // Random ops/data with hold toggling and random source backpressure
    do_reset();
    hold_mode = 1'b1;
    rand_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      op = 2'($urandom_range(0, 3));
      send({$urandom, $urandom}, 8'($urandom), (i % 8) == 7, 4'($urandom), 4'($urandom));
    end
    drain();
    hold_mode = 1'b0;
    rand_ready = 1'b0;
    hold = 1'b0;
    src_rsp.tready = 1'b1;
    chk("rand_count", 128'(got_q.size()), 128'(32));
    chk("rand_beat_cnt", 128'(beat_cnt), 128'(32));
    chk("rand_pkt_cnt", 128'(pkt_cnt), 128'(4));

    // Reset with five beats of an open packet buffered
    do_reset();
    op = 2'd0;
    src_rsp.tready = 1'b0;
    for (int i = 0; i < 5; i++) send(64'(200 + i), 8'hFF, 1'b0, 4'd0, 4'd0);
    chk("mid_level", 128'(level), 128'(5));
    rst = 1'b1;
    sink_req.tvalid = 1'b0;
    step();
    rst = 1'b0;
    chk("mid_rst_level", 128'(level), 128'(0));
    chk("mid_rst_beat_cnt", 128'(beat_cnt), 128'(0));
    chk("mid_rst_pkt_cnt", 128'(pkt_cnt), 128'(0));
    chk("mid_rst_src_valid", 128'(src_req.tvalid), 128'(0));
    chk("mid_rst_sink_ready", 128'(sink_rsp.tready), 128'(0));
    step();
    chk("mid_sink_ready", 128'(sink_rsp.tready), 128'(1));
    src_rsp.tready = 1'b1;
    got_q.delete();
    for (int i = 0; i < 3; i++) send(64'(300 + i), 8'hFF, i == 2, 4'd6, 4'd9);
    drain();
    chk("mid_count", 128'(got_q.size()), 128'(3));
    for (int i = 0; i < 3; i++) chk("mid_data", 128'(got_q[i].tdata), 128'(300 + i));
    chk("mid_pkt_cnt", 128'(pkt_cnt), 128'(1));
    chk("mid_beat_cnt", 128'(beat_cnt), 128'(3));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
